// File: rtl/and16_arb_pkg.sv
// Shared types and constants for the round-robin arbitrated AND16/OR16/NOT16/NAND16 unit.
package and16_arb_pkg;

    localparam int WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_NOT  = 2'b10,
        OP_NAND = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_e;

endpackage

// File: rtl/and16_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid request at or after the pointer, cyclic.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [PTR_W-1:0]   winner_o,
    output logic               any_valid_o
);

    // Two ascending scans: indices >= ptr first, then indices below ptr, which gives cyclic priority.
    always_comb begin
        // NOTE: every output gets a default before the scans so no path leaves it unassigned (no latch).
        grant_o     = '0;
        winner_o    = '0;
        any_valid_o = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any_valid_o && req_i[i] && (i >= int'(ptr_i))) begin
                any_valid_o = 1'b1;
                winner_o    = PTR_W'(i);
                grant_o[i]  = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any_valid_o && req_i[i] && (i < int'(ptr_i))) begin
                any_valid_o = 1'b1;
                winner_o    = PTR_W'(i);
                grant_o[i]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/and16_rr_arbiter.sv
// One shared 16-bit bitwise unit (AND/OR/NOT A/NAND) arbitrated round-robin between NUM_REQ requesters.
// Optional feature macro AND16_ARB_FLAGS_EN adds registered zr_o/ng_o result flags.
module and16_rr_arbiter
    import and16_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = WIDTH_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    input  logic [NUM_REQ*WIDTH-1:0] req_a_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_b_i,
    input  logic [NUM_REQ*2-1:0]   req_op_i,
    output logic [NUM_REQ-1:0]     resp_valid_o,
    input  logic [NUM_REQ-1:0]     resp_ready_i,
    output logic [WIDTH-1:0]       resp_y_o,
    output logic                   busy_o
`ifdef AND16_ARB_FLAGS_EN
    ,
    output logic                   zr_o,
    output logic                   ng_o
`endif
);

    localparam int PTR_W = $clog2(NUM_REQ);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [PTR_W-1:0]   r_win;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    op_e                r_op;
    logic [WIDTH-1:0]   r_y;

    logic [NUM_REQ-1:0] w_grant;
    logic [PTR_W-1:0]   w_winner;
    logic               w_any;
    logic [WIDTH-1:0]   w_a_sel;
    logic [WIDTH-1:0]   w_b_sel;
    logic [1:0]         w_op_sel;
    logic [WIDTH-1:0]   w_y;
    logic [PTR_W-1:0]   w_ptr_nxt;
    logic [NUM_REQ-1:0] w_win_onehot;
    logic               w_accept;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req_i       (req_valid_i),
        .ptr_i       (r_rr_ptr),
        .grant_o     (w_grant),
        .winner_o    (w_winner),
        .any_valid_o (w_any)
    );

    // Route the winning requester's operands and op to the capture registers.
    always_comb begin
        w_a_sel  = '0;
        w_b_sel  = '0;
        w_op_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_a_sel  = req_a_i[i*WIDTH +: WIDTH];
                w_b_sel  = req_b_i[i*WIDTH +: WIDTH];
                w_op_sel = req_op_i[i*2 +: 2];
            end
        end
    end

    // Bitwise function on the latched operands; no carries between bits.
    always_comb begin
        w_y = '0;
        case (r_op)
            OP_AND:  w_y = r_a & r_b;
            OP_OR:   w_y = r_a | r_b;
            OP_NOT:  w_y = ~r_a;
            OP_NAND: w_y = ~(r_a & r_b);
            default: w_y = '0;
        endcase
    end

    assign w_accept     = (r_state == IDLE) && w_any;
    assign w_ptr_nxt    = (w_winner == PTR_W'(NUM_REQ - 1)) ? '0 : w_winner + PTR_W'(1);
    assign w_win_onehot = NUM_REQ'(1) << r_win;

    // Next-state logic for the IDLE -> EXEC -> RESP -> IDLE sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any) w_state_nxt = EXEC;
            EXEC:    w_state_nxt = RESP;
            RESP:    if (resp_ready_i[r_win]) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register; reset drops any in-flight operation.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Capture the winner's request on accept and advance the round-robin pointer past it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: operand/op/winner registers are reset as well; they are a handful of flops, not a memory array.
        if (rst_i) begin
            r_rr_ptr <= '0;
            r_win    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= OP_AND;
        end else if (w_accept) begin
            r_rr_ptr <= w_ptr_nxt;
            r_win    <= w_winner;
            r_a      <= w_a_sel;
            r_b      <= w_b_sel;
            r_op     <= op_e'(w_op_sel);
        end
    end

    // Register the result in EXEC; it then holds through RESP until the next operation.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                r_y <= '0;
        else if (r_state == EXEC) r_y <= w_y;
    end

`ifdef AND16_ARB_FLAGS_EN
    logic r_zr;
    logic r_ng;

    // Hack-ALU style flags, registered alongside the result.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_zr <= 1'b0;
            r_ng <= 1'b0;
        end else if (r_state == EXEC) begin
            r_zr <= (w_y == '0);
            r_ng <= w_y[WIDTH-1];
        end
    end

    assign zr_o = r_zr;
    assign ng_o = r_ng;
`endif

    // Ready is only offered in IDLE and is forced low while reset is asserted.
    assign req_ready_o  = (w_accept && !rst_i) ? w_grant : '0;
    assign resp_valid_o = (r_state == RESP) ? w_win_onehot : '0;
    assign resp_y_o     = r_y;
    assign busy_o       = (r_state != IDLE);

endmodule
